// File: rtl/thumb_fetch_aligner.sv
//------------------------------------------------------------------------------
// thumb_fetch_aligner: fetches 32-bit words, buffers halfwords and presents
// one complete 16/32-bit Thumb instruction per decoder handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module thumb_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_fetch_req,
  output logic [31:0] o_fetch_addr,
  input  logic        i_fetch_ack,
  input  logic [31:0] i_fetch_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_is32,
  input  logic        i_inst_ready
);

  localparam int PTR_W = $clog2(BUF_HW);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [31:0]      c_reset_fetch = RESET_PC & ~32'd3;
  localparam logic [31:0]      c_reset_pc    = RESET_PC & ~32'd1;
  localparam logic [CNT_W-1:0] c_req_thresh  = CNT_W'(BUF_HW - 2);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two         = CNT_W'(2);

  typedef enum logic {
    S_STREAM = 1'b0,
    S_ALIGN  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_fetch_req;
  logic [31:0]        r_fetch_addr;
  logic [31:0]        r_pc;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [15:0]        r_buf [BUF_HW];
  logic               r_inst_valid;
  logic [31:0]        r_inst;
  logic [31:0]        r_inst_pc;
  logic               r_inst_is32;

  logic               w_xfer;
  logic [PTR_W-1:0]   w_rd_ptr_p1;
  logic [PTR_W-1:0]   w_wr_ptr_p1;
  logic [15:0]        w_h0;
  logic [15:0]        w_h1;
  logic               w_is32;
  logic               w_load;
  logic [CNT_W-1:0]   w_push;
  logic [CNT_W-1:0]   w_pop;
  logic [CNT_W-1:0]   w_count_next;

  assign w_xfer      = r_fetch_req && i_fetch_ack;
  assign w_rd_ptr_p1 = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_h0        = r_buf[r_rd_ptr];
  assign w_h1        = r_buf[w_rd_ptr_p1];
  assign w_is32      = (w_h0[15:13] == 3'b111) && (w_h0[12:11] != 2'b00);

  // Load decision sees only the pre-push occupancy; fresh fetch data waits a cycle.
  assign w_load       = (!r_inst_valid || i_inst_ready) &&
                        (w_is32 ? (r_count >= c_two) : (r_count >= c_one));
  assign w_push       = !w_xfer ? '0 : ((r_state == S_ALIGN) ? c_one : c_two);
  assign w_pop        = !w_load ? '0 : (w_is32 ? c_two : c_one);
  assign w_count_next = r_count + w_push - w_pop;

  always_ff @(posedge clk) begin
    if (w_xfer && !i_redirect) begin
      if (r_state == S_ALIGN) begin
        r_buf[r_wr_ptr] <= i_fetch_data[31:16];
      end else begin
        r_buf[r_wr_ptr]    <= i_fetch_data[15:0];
        r_buf[w_wr_ptr_p1] <= i_fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RESET_PC[1] ? S_ALIGN : S_STREAM;
      r_fetch_req  <= 1'b0;
      r_fetch_addr <= c_reset_fetch;
      r_pc         <= c_reset_pc;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= c_reset_pc;
      r_inst_is32  <= 1'b0;
    end else if (i_redirect) begin
      r_state      <= i_redirect_pc[1] ? S_ALIGN : S_STREAM;
      r_fetch_req  <= 1'b0;
      r_fetch_addr <= i_redirect_pc & ~32'd3;
      r_pc         <= i_redirect_pc & ~32'd1;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_fetch_req <= (w_count_next <= c_req_thresh);
      r_count     <= w_count_next;
      r_wr_ptr    <= r_wr_ptr + w_push[PTR_W-1:0];
      r_rd_ptr    <= r_rd_ptr + w_pop[PTR_W-1:0];
      if (w_xfer) begin
        r_fetch_addr <= r_fetch_addr + 32'd4;
        r_state      <= S_STREAM;
      end
      if (w_load) begin
        r_inst_valid <= 1'b1;
        r_inst       <= w_is32 ? {w_h0, w_h1} : {w_h0, 16'h0000};
        r_inst_pc    <= r_pc;
        r_inst_is32  <= w_is32;
        r_pc         <= r_pc + (w_is32 ? 32'd4 : 32'd2);
      end else if (r_inst_valid && i_inst_ready) begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign o_fetch_req  = r_fetch_req;
  assign o_fetch_addr = r_fetch_addr;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_is32  = r_inst_is32;

endmodule

`default_nettype wire

// File: tb/tb_thumb_fetch_aligner.sv
//------------------------------------------------------------------------------
// tb_thumb_fetch_aligner: directed scenario tasks for thumb_fetch_aligner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_thumb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_fetch_req;
  logic [31:0] o_fetch_addr;
  logic        i_fetch_ack = 1'b0;
  logic [31:0] i_fetch_data;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_is32;
  logic        i_inst_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 1;

  // Mode 1: constant ADC words. Mode 2: halfword at a is {4'h1, a[11:0]}.
  // Mode 3: split 32-bit instruction across the first two words.
  function automatic logic [31:0] word_for(input int m, input logic [31:0] a);
    logic [31:0] a2;
    a2 = a + 32'd2;
    case (m)
      1:       word_for = 32'h4148_4148;
      2:       word_for = {4'h1, a2[11:0], 4'h1, a[11:0]};
      3:       word_for = (a == 32'd0) ? 32'hF101_0000 :
                          (a == 32'd4) ? 32'h0000_0203 : 32'h0000_0000;
      default: word_for = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_inst2(input logic [31:0] pc);
    exp_inst2 = {4'h1, pc[11:0], 16'h0000};
  endfunction

  assign i_fetch_data = word_for(mode, o_fetch_addr);

  always #5 clk = ~clk;

  thumb_fetch_aligner #(
    .RESET_PC (32'h0000_0000),
    .BUF_HW   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .o_fetch_req   (o_fetch_req),
    .o_fetch_addr  (o_fetch_addr),
    .i_fetch_ack   (i_fetch_ack),
    .i_fetch_data  (i_fetch_data),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_inst_is32   (o_inst_is32),
    .i_inst_ready  (i_inst_ready)
  );

  task automatic do_redirect(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    @(negedge clk);
    i_redirect    = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (o_fetch_req !== 1'b0) $display("FAIL rst_req: got %b want 0", o_fetch_req); else n_pass++;
    n_checks++; if (o_fetch_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", o_fetch_addr); else n_pass++;
    n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_inst_valid); else n_pass++;
    n_checks++; if (o_inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", o_inst); else n_pass++;
    n_checks++; if (o_inst_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", o_inst_pc); else n_pass++;
    n_checks++; if (o_inst_is32 !== 1'b0) $display("FAIL rst_is32: got %b want 0", o_inst_is32); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    int first_x = -1;
    int first_v = -1;
    int n_x = 0;
    int n_i = 0;
    mode = 1; i_fetch_ack = 1'b1; i_inst_ready = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (o_fetch_req && i_fetch_ack && n_x < 3) begin
        if (first_x < 0) first_x = c;
        n_checks++; if (o_fetch_addr !== exp_addr) $display("FAIL stream_addr: got %h want %h", o_fetch_addr, exp_addr); else n_pass++;
        exp_addr += 32'd4; n_x++;
      end
      if (first_v < 0 && o_inst_valid) first_v = c;
      if (first_v >= 0) begin
        n_checks++; if (o_inst_valid !== 1'b1) $display("FAIL stream_gap: got valid %b want 1", o_inst_valid); else n_pass++;
        if (o_inst_valid) begin
          n_checks++; if (o_inst !== 32'h4148_0000) $display("FAIL stream_inst: got %h want 41480000", o_inst); else n_pass++;
          n_checks++; if (o_inst_is32 !== 1'b0) $display("FAIL stream_is32: got %b want 0", o_inst_is32); else n_pass++;
          n_checks++; if (o_inst_pc !== exp_pc) $display("FAIL stream_pc: got %h want %h", o_inst_pc, exp_pc); else n_pass++;
          exp_pc += 32'd2; n_i++;
        end
      end
    end
    n_checks++; if (n_x !== 3) $display("FAIL stream_nxfer: got %0d want 3", n_x); else n_pass++;
    n_checks++; if (first_v !== first_x + 2) $display("FAIL stream_latency: got %0d want %0d", first_v, first_x + 2); else n_pass++;
    n_checks++; if (n_i !== 12) $display("FAIL stream_count: got %0d want 12", n_i); else n_pass++;
  endtask

  task automatic test_split();
    i_fetch_ack = 1'b0; i_inst_ready = 1'b1;
    mode = 3;
    do_redirect(32'h0);
    for (int k = 0; k < 5 && !o_fetch_req; k++) @(negedge clk);
    n_checks++; if (o_fetch_req !== 1'b1 || o_fetch_addr !== 32'h0) $display("FAIL split_req0: got req %b addr %h want 1 00000000", o_fetch_req, o_fetch_addr); else n_pass++;
    i_fetch_ack = 1'b1;
    @(negedge clk);
    i_fetch_ack = 1'b0;
    n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL split_lat: got valid %b want 0", o_inst_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_inst_valid !== 1'b1 || o_inst !== 32'h0 || o_inst_pc !== 32'h0 || o_inst_is32 !== 1'b0)
      $display("FAIL split_first: got v%b %h pc %h is32 %b want v1 00000000 pc 0 is32 0", o_inst_valid, o_inst, o_inst_pc, o_inst_is32); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL split_hold: got valid %b want 0", o_inst_valid); else n_pass++;
      n_checks++; if (o_fetch_req !== 1'b1 || o_fetch_addr !== 32'h4) $display("FAIL split_req4: got req %b addr %h want 1 00000004", o_fetch_req, o_fetch_addr); else n_pass++;
    end
    i_fetch_ack = 1'b1;
    @(negedge clk);
    i_fetch_ack = 1'b0;
    n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL split_nobypass: got valid %b want 0", o_inst_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_inst_valid !== 1'b1 || o_inst !== 32'hF101_0203 || o_inst_pc !== 32'h2 || o_inst_is32 !== 1'b1)
      $display("FAIL split_32: got v%b %h pc %h is32 %b want v1 f1010203 pc 2 is32 1", o_inst_valid, o_inst, o_inst_pc, o_inst_is32); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_inst_valid !== 1'b1 || o_inst !== 32'h0 || o_inst_pc !== 32'h6 || o_inst_is32 !== 1'b0)
      $display("FAIL split_tail: got v%b %h pc %h is32 %b want v1 00000000 pc 6 is32 0", o_inst_valid, o_inst, o_inst_pc, o_inst_is32); else n_pass++;
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc = 32'h102;
    int n_x = 0;
    int n_i = 0;
    mode = 2; i_fetch_ack = 1'b1; i_inst_ready = 1'b1;
    for (int k = 0; k < 5 && !o_fetch_req; k++) @(negedge clk);
    n_checks++; if (o_fetch_req !== 1'b1) $display("FAIL redir_pending: got req %b want 1", o_fetch_req); else n_pass++;
    do_redirect(32'h0000_0102);
    n_checks++; if (o_inst_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", o_inst_valid); else n_pass++;
    n_checks++; if (o_fetch_req !== 1'b0) $display("FAIL redir_req: got %b want 0", o_fetch_req); else n_pass++;
    n_checks++; if (o_fetch_addr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", o_fetch_addr); else n_pass++;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_fetch_req && n_x == 0) begin
        n_checks++; if (o_fetch_addr !== 32'h100) $display("FAIL redir_xaddr: got %h want 00000100", o_fetch_addr); else n_pass++;
        n_x++;
      end
      if (o_inst_valid) begin
        n_checks++; if (o_inst_pc !== exp_pc || o_inst !== exp_inst2(exp_pc))
          $display("FAIL redir_seq: got pc %h inst %h want pc %h inst %h", o_inst_pc, o_inst, exp_pc, exp_inst2(exp_pc)); else n_pass++;
        exp_pc += 32'd2; n_i++;
      end
    end
    n_checks++; if (n_i < 10) $display("FAIL redir_count: got %0d want >=10", n_i); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc = 32'h202;
    int n_x = 0;
    int n_v = 0;
    int n_i = 0;
    i_inst_ready = 1'b0; i_fetch_ack = 1'b1;
    do_redirect(32'h0000_0200);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_fetch_req && i_fetch_ack) n_x++;
      if (o_inst_valid) begin
        n_checks++; if (o_inst !== 32'h1200_0000 || o_inst_pc !== 32'h200)
          $display("FAIL bp_stable: got %h pc %h want 12000000 pc 00000200", o_inst, o_inst_pc); else n_pass++;
        n_v++;
      end
    end
    n_checks++; if (n_x !== 2) $display("FAIL bp_nxfer: got %0d want 2", n_x); else n_pass++;
    n_checks++; if (n_v !== 8) $display("FAIL bp_nvalid: got %0d want 8", n_v); else n_pass++;
    n_checks++; if (o_fetch_req !== 1'b0) $display("FAIL bp_req: got %b want 0", o_fetch_req); else n_pass++;
    i_inst_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_inst_valid) begin
        n_checks++; if (o_inst_pc !== exp_pc || o_inst !== exp_inst2(exp_pc))
          $display("FAIL bp_seq: got pc %h inst %h want pc %h inst %h", o_inst_pc, o_inst, exp_pc, exp_inst2(exp_pc)); else n_pass++;
        exp_pc += 32'd2; n_i++;
      end
    end
    n_checks++; if (n_i < 10) $display("FAIL bp_count: got %0d want >=10", n_i); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr = 32'hFFFF_FFFC;
    logic [31:0] exp_pc = 32'hFFFF_FFFC;
    int n_x = 0;
    int n_i = 0;
    i_inst_ready = 1'b1; i_fetch_ack = 1'b1;
    do_redirect(32'hFFFF_FFFC);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_fetch_req && n_x < 2) begin
        n_checks++; if (o_fetch_addr !== exp_addr) $display("FAIL wrap_addr: got %h want %h", o_fetch_addr, exp_addr); else n_pass++;
        exp_addr += 32'd4; n_x++;
      end
      if (o_inst_valid && n_i < 4) begin
        n_checks++; if (o_inst_pc !== exp_pc || o_inst !== exp_inst2(exp_pc))
          $display("FAIL wrap_seq: got pc %h inst %h want pc %h inst %h", o_inst_pc, o_inst, exp_pc, exp_inst2(exp_pc)); else n_pass++;
        exp_pc += 32'd2; n_i++;
      end
    end
    n_checks++; if (n_x !== 2 || n_i !== 4) $display("FAIL wrap_count: got xfer %0d inst %0d want 2 4", n_x, n_i); else n_pass++;
  endtask

  task automatic test_async_reset();
    int n_i = 0;
    @(negedge clk);
    n_checks++; if (o_inst_valid !== 1'b1) $display("FAIL arst_pre: got valid %b want 1", o_inst_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_fetch_req !== 1'b0 || o_fetch_addr !== 32'h0) $display("FAIL arst_fetch: got req %b addr %h want 0 0", o_fetch_req, o_fetch_addr); else n_pass++;
    n_checks++; if (o_inst_valid !== 1'b0 || o_inst !== 32'h0) $display("FAIL arst_inst: got v%b %h want v0 0", o_inst_valid, o_inst); else n_pass++;
    n_checks++; if (o_inst_pc !== 32'h0 || o_inst_is32 !== 1'b0) $display("FAIL arst_pc: got %h is32 %b want 0 0", o_inst_pc, o_inst_is32); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_inst_valid && n_i == 0) begin
        n_checks++; if (o_inst_pc !== 32'h0 || o_inst !== 32'h1000_0000)
          $display("FAIL arst_restart: got pc %h inst %h want 0 10000000", o_inst_pc, o_inst); else n_pass++;
        n_i++;
      end
    end
    n_checks++; if (n_i !== 1) $display("FAIL arst_resume: got %0d want 1", n_i); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_split();
    test_redirect();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thumb_fetch_aligner.md
Name: thumb_fetch_aligner

Overview:
- Sequences the instruction stream into the Thumb instruction pattern decoder.
- Fetches aligned 32-bit words from instruction memory and buffers them as halfwords.
- Identifies 16-bit versus 32-bit Thumb encodings and presents one complete instruction per handshake in the decoder's inst[31:0] layout.
- Handles branch redirects, including entry at a halfword-aligned PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first instruction after reset; bit 0 ignored.
- BUF_HW, 4, halfword buffer depth; power of 2, at least 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  out  1  word fetch request; registered.
- fetch_addr  out  32  word address of the request; bits [1:0] always 0.
- fetch_ack  in  1  request accepted; fetch_data is valid in the same cycle.
- fetch_data  in  32  [15:0] is the halfword at fetch_addr; [31:16] is the halfword at fetch_addr+2.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  32  new PC; bit 0 ignored.
- inst_valid  out  1  inst, inst_pc and inst_is32 are valid.
- inst  out  32  16-bit encoding: {hw,16'h0000}. 32-bit encoding: {hw1,hw2}.
- inst_pc  out  32  address of the first halfword of inst.
- inst_is32  out  1  inst is a 32-bit encoding.
- inst_ready  in  1  decoder accepts inst this cycle.

Behaviour:
- Reset values (rst high):
  - fetch_req=0, fetch_addr=RESET_PC&~3, inst_valid=0, inst=0, inst_pc=RESET_PC&~1, inst_is32=0.
  - Buffer count=0, align flag=RESET_PC[1].
- Fetch handshake:
  - A transfer occurs on a cycle with fetch_req && fetch_ack.
  - fetch_req and fetch_addr are held stable until that transfer or a redirect.
  - After a transfer, fetch_addr += 4 (wraps modulo 2^32).
  - fetch_req next value = (count_next <= BUF_HW-2) && !redirect, where count_next is the post-update count.
  - A transfer therefore always finds at least 2 free slots; the buffer never overflows.
- Align flag (two-state FSM, ALIGN / STREAM):
  - In ALIGN: a transfer pushes only fetch_data[31:16], then moves to STREAM.
  - In STREAM: a transfer pushes [15:0] then [31:16].
- Encoding detection on the buffer head halfword h0:
  - is32 = (h0[15:11] == 5'b11101) || (h0[15:11] == 5'b11110) || (h0[15:11] == 5'b11111).
- Output stage:
  - Loads when (!inst_valid || inst_ready) and the buffer holds a full instruction: count>=1 for 16-bit, count>=2 for 32-bit.
  - On load: pop 1 or 2 halfwords; inst_pc takes the internal PC; internal PC += 2 or 4.
  - Pop/load decisions use the pre-push count; no bypass from fetch_data.
  - If inst_valid && inst_ready and nothing is loadable, inst_valid drops to 0.
  - inst, inst_pc and inst_is32 hold while inst_valid && !inst_ready.
- Latency: word transferred at edge N; the first instruction is visible with inst_valid=1 after edge N+1.
- Simultaneous push and pop: count_next = count + pushed - popped. The buffer is circular; read/write pointers wrap modulo BUF_HW.
- Redirect has the highest priority:
  - Buffer is emptied, inst_valid=0, fetch_req=0 for one cycle.
  - fetch_addr=redirect_pc&~3, internal PC=redirect_pc&~1, align flag=redirect_pc[1].
  - Any fetch_ack or inst_ready in the same cycle is ignored: data discarded, no pop.
- rst asserted mid-operation: immediate return to reset values; in-flight fetch is abandoned.
- A 32-bit instruction split across two fetched words is held until the second halfword arrives; inst_valid stays low meanwhile.

Test Plan:
- Reset with RESET_PC=0, ack every request with words 0x4148_4148:
  - -> fetch_addr sequence 0,4,8.
  - -> inst=0x4148_0000 (ADC T1), inst_is32=0, inst_pc 0,2,4,6, one instruction per cycle once streaming.
- Word 0xF101_0000 at addr 0 (hw0=0x0000, hw1=0xF101), then 0x0000_0203 at addr 4:
  - -> 16-bit inst 0x0000_0000 at pc 0.
  - -> then inst=0xF101_0203, inst_is32=1, pc 2, spanning the word boundary.
- Redirect to 0x0000_0102 while a request is pending and fetch_ack is high the same cycle:
  - -> acked data dropped, inst_valid=0 next cycle.
  - -> fetch_addr=0x100; only the upper halfword of the next word is used; first inst_pc=0x102.
- Hold inst_ready=0 for 10 cycles with acks always available:
  - -> inst stable.
  - -> fetch_req drops once count>2 (BUF_HW=4).
  - -> no halfword lost or duplicated after inst_ready returns high.
- fetch_addr=0xFFFF_FFFC transfer -> next fetch_addr=0x0000_0000; internal PC wraps identically.
- Assert rst asynchronously mid-stream with inst_valid=1 -> all outputs at reset values before the next clk edge.
